// File: rtl/fc_layer.sv
// Fully-connected layer: y[o] = sat(bias[o] + sum_k w[o][k]*x[k]) in signed
// fixed point. The layer walks the flattened pooled map held in DRAM over a
// single-port bus with one outstanding read. Each result is written back to
// the region that the next layer reads as its input.
module fc_layer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int FRAC_BITS  = 16,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_wr,
    output logic                  dram_en_rd,
    output logic                  done
);

    localparam int ACC_W = 2*DATA_WIDTH + 8;
    localparam int PRD_W = 2*DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] N_ADDR = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] M_ADDR = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] X_BASE = ADDR_WIDTH'(65536);
    localparam logic [ADDR_WIDTH-1:0] Y_BASE = ADDR_WIDTH'(131072);
    localparam logic [ADDR_WIDTH-1:0] W_BASE = ADDR_WIDTH'(196608);
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  C_ONE  = CNT_WIDTH'(1);

    localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_N,
        S_LD_M,
        S_LD_BIAS,
        S_LD_X,
        S_LD_W,
        S_WR,
        S_DONE
    } state_t;

    state_t                         r_state;
    logic        [CNT_WIDTH-1:0]    r_n;
    logic        [CNT_WIDTH-1:0]    r_m;
    logic        [CNT_WIDTH-1:0]    r_k;
    logic        [CNT_WIDTH-1:0]    r_o;
    logic        [ADDR_WIDTH-1:0]   r_wptr;
    logic signed [DATA_WIDTH-1:0]   r_x;
    logic signed [ACC_W-1:0]        r_acc;
    logic        [DATA_WIDTH-1:0]   r_data_out;
    logic        [ADDR_WIDTH-1:0]   r_addr_out;
    logic                           r_wr_en;
    logic                           r_done;

    logic signed [DATA_WIDTH-1:0]   w_din;
    logic signed [PRD_W-1:0]        w_prod;
    logic signed [ACC_W-1:0]        w_acc_mac;
    logic signed [ACC_W-1:0]        w_acc_bias;
    logic signed [ACC_W-1:0]        w_acc_fin;
    logic signed [ACC_W-1:0]        w_shift;
    logic        [DATA_WIDTH-1:0]   w_sat;
    logic                           w_in_range;
    logic                           w_k_last;
    logic                           w_o_last;
    logic        [CNT_WIDTH-1:0]    w_din_cnt;

    assign w_din     = data_in;
    assign w_din_cnt = data_in[CNT_WIDTH-1:0];

    // Full-width signed product and accumulator update; the 8 guard bits
    // keep long dot products from wrapping.
    assign w_prod     = r_x * w_din;
    assign w_acc_mac  = r_acc + {{(ACC_W-PRD_W){w_prod[PRD_W-1]}}, w_prod};
    assign w_acc_bias = {{(ACC_W-DATA_WIDTH){w_din[DATA_WIDTH-1]}}, w_din} <<< FRAC_BITS;

    // Accumulator value that will be final when the FSM enters WR: either the
    // bias alone (N==0) or the last MAC. The output register loads on entry.
    assign w_acc_fin = (r_state == S_LD_BIAS) ? w_acc_bias : w_acc_mac;
    assign w_shift   = w_acc_fin >>> FRAC_BITS;

    // The value fits when every bit above the result's sign bit matches it.
    assign w_in_range = (&w_shift[ACC_W-1:DATA_WIDTH-1]) | ~(|w_shift[ACC_W-1:DATA_WIDTH-1]);
    assign w_sat      = w_in_range ? w_shift[DATA_WIDTH-1:0]
                                   : (w_shift[ACC_W-1] ? SAT_NEG : SAT_POS);

    assign w_k_last = (r_k == r_n - C_ONE);
    assign w_o_last = (r_o == r_m - C_ONE);

    // Read request and address decode straight from the state register, so
    // the address holds steady for as long as the request waits for data.
    always_comb begin
        dram_en_rd = 1'b0;
        addr_in    = '0;
        case (r_state)
            S_LD_N: begin
                dram_en_rd = 1'b1;
                addr_in    = N_ADDR;
            end
            S_LD_M: begin
                dram_en_rd = 1'b1;
                addr_in    = M_ADDR;
            end
            S_LD_BIAS, S_LD_W: begin
                dram_en_rd = 1'b1;
                addr_in    = r_wptr;
            end
            S_LD_X: begin
                dram_en_rd = 1'b1;
                addr_in    = X_BASE + {{(ADDR_WIDTH-CNT_WIDTH){1'b0}}, r_k};
            end
            default: begin
                dram_en_rd = 1'b0;
                addr_in    = '0;
            end
        endcase
    end

    assign data_out   = r_data_out;
    assign addr_out   = r_addr_out;
    assign dram_en_wr = r_wr_en;
    assign done       = r_done;

    // Control FSM. It also owns the datapath registers. The write strobe and
    // done are loaded on entry to WR and DONE, so each is high only for the
    // cycle spent in that state.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_m        <= '0;
            r_k        <= '0;
            r_o        <= '0;
            r_wptr     <= '0;
            r_x        <= '0;
            r_acc      <= '0;
            r_data_out <= '0;
            r_addr_out <= '0;
            r_wr_en    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_LD_N;
                        r_wptr  <= W_BASE;
                        r_k     <= '0;
                        r_o     <= '0;
                        r_acc   <= '0;
                    end
                end
                S_LD_N: begin
                    if (dram_valid) begin
                        r_n     <= w_din_cnt;
                        r_state <= S_LD_M;
                    end
                end
                S_LD_M: begin
                    if (dram_valid) begin
                        r_m <= w_din_cnt;
                        if (w_din_cnt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LD_BIAS;
                        end
                    end
                end
                S_LD_BIAS: begin
                    if (dram_valid) begin
                        r_acc  <= w_acc_bias;
                        r_wptr <= r_wptr + A_ONE;
                        if (r_n == '0) begin
                            r_state    <= S_WR;
                            r_wr_en    <= 1'b1;
                            r_addr_out <= Y_BASE + {{(ADDR_WIDTH-CNT_WIDTH){1'b0}}, r_o};
                            r_data_out <= w_sat;
                        end else begin
                            r_state <= S_LD_X;
                        end
                    end
                end
                S_LD_X: begin
                    if (dram_valid) begin
                        r_x     <= w_din;
                        r_state <= S_LD_W;
                    end
                end
                S_LD_W: begin
                    if (dram_valid) begin
                        r_acc  <= w_acc_mac;
                        r_wptr <= r_wptr + A_ONE;
                        if (w_k_last) begin
                            r_k        <= '0;
                            r_state    <= S_WR;
                            r_wr_en    <= 1'b1;
                            r_addr_out <= Y_BASE + {{(ADDR_WIDTH-CNT_WIDTH){1'b0}}, r_o};
                            r_data_out <= w_sat;
                        end else begin
                            r_k     <= r_k + C_ONE;
                            r_state <= S_LD_X;
                        end
                    end
                end
                S_WR: begin
                    if (w_o_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_o     <= r_o + C_ONE;
                        r_state <= S_LD_BIAS;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer. A DRAM model serves reads with a chosen latency.
// Each stimulus pushes its expected writes onto a queue, and a monitor pops
// that queue and compares whenever the DUT strobes a write.
module tb_fc_layer;

    localparam int XB = 65536;
    localparam int YB = 131072;
    localparam int WB = 196608;

    logic        clk;
    logic        srstn;
    logic        enable;
    logic        dram_valid;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [17:0] addr_in;
    logic [17:0] addr_out;
    logic        dram_en_wr;
    logic        dram_en_rd;
    logic        done;

    fc_layer dut (
        .clk        (clk),
        .srstn      (srstn),
        .enable     (enable),
        .dram_valid (dram_valid),
        .data_in    (data_in),
        .data_out   (data_out),
        .addr_in    (addr_in),
        .addr_out   (addr_out),
        .dram_en_wr (dram_en_wr),
        .dram_en_rd (dram_en_rd),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem [0:262143];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    int          x_reads = 0;
    bit          rand_dly = 1'b0;
    int          r_wait = 0;
    int          cur_delay = 0;
    logic [17:0] held_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DRAM read port: data is the addressed word, valid once the wait elapses.
    assign data_in    = mem[addr_in];
    assign dram_valid = dram_en_rd && (r_wait >= cur_delay);

    // Latency sequencer: counts wait cycles and draws the next latency.
    always @(posedge clk) begin
        if (dram_en_rd) begin
            if (dram_valid) begin
                r_wait    <= 0;
                cur_delay <= rand_dly ? int'($urandom_range(0, 5)) : 0;
            end else begin
                r_wait <= r_wait + 1;
            end
        end
    end

    // Monitor: checks writes against the scoreboard, bus exclusivity and
    // address stability while a read waits.
    always @(negedge clk) begin
        if (srstn) begin
            if (dram_en_wr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", {46'd0, addr_out}, 64'h3_FFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", {46'd0, addr_out}, {46'd0, e.a});
                    chk("write_data", {32'd0, data_out}, {32'd0, e.d});
                end
                if (dram_en_rd) chk("rd_wr_exclusive", 64'd1, 64'd0);
            end
            if (done) done_cnt++;
            if (dram_en_rd && dram_valid && addr_in >= 18'(XB) && addr_in < 18'(YB)) x_reads++;
            if (dram_en_rd) begin
                if (r_wait == 0) held_addr = addr_in;
                else chk("addr_rd_stable", {46'd0, addr_in}, {46'd0, held_addr});
            end
        end
    end

    task automatic push(input int a, input logic [31:0] d);
        wr_t e;
        e.a = 18'(a);
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Pulse enable, wait for done (bounded), then confirm that nothing else happens.
    task automatic run_layer(input bit glitch, output int cyc);
        done_cnt = 0;
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            enable = (glitch && cyc == 4);
        end
        enable = 1'b0;
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("single_done", 64'(done_cnt), 64'd1);
    endtask

    // Hand-computed N=3, M=2 layer:
    // row0 = 0.25 + 1*2 + (-2)*0.5 + 0.5*(-1) = 0.75
    // row1 = -1 + 1*0.5 + (-2)*0.25 + 0.5*4 = 1.0
    task automatic setup_n3m2();
        mem[3] = 3; mem[4] = 2;
        mem[XB+0] = 32'h0001_0000; mem[XB+1] = 32'hFFFE_0000; mem[XB+2] = 32'h0000_8000;
        mem[WB+0] = 32'h0000_4000; mem[WB+1] = 32'h0002_0000;
        mem[WB+2] = 32'h0000_8000; mem[WB+3] = 32'hFFFF_0000;
        mem[WB+4] = 32'hFFFF_0000; mem[WB+5] = 32'h0000_8000;
        mem[WB+6] = 32'h0000_4000; mem[WB+7] = 32'h0004_0000;
        push(YB+0, 32'h0000_C000);
        push(YB+1, 32'h0001_0000);
    endtask

    task automatic setup_n1(input logic [31:0] x, input logic [31:0] w, input logic [31:0] y);
        mem[3] = 1; mem[4] = 1;
        mem[XB] = x;
        mem[WB] = 32'd0; mem[WB+1] = w;
        push(YB, y);
    endtask

    initial begin
        int cyc;
        int guard;
        for (int i = 0; i < 262144; i++) mem[i] = '0;
        srstn  = 1'b0;
        enable = 1'b0;
        #22;
        chk("rst_data_out", {32'd0, data_out}, 64'd0);
        chk("rst_addr_out", {46'd0, addr_out}, 64'd0);
        chk("rst_ctrl", {61'd0, dram_en_rd, dram_en_wr, done}, 64'd0);
        @(posedge clk); #1 srstn = 1'b1;

        // 1.0*0.5 + 2.0*0.25 + bias 1.0 = 2.0
        mem[3] = 2; mem[4] = 1;
        mem[XB] = 32'h0001_0000; mem[XB+1] = 32'h0002_0000;
        mem[WB] = 32'h0001_0000; mem[WB+1] = 32'h0000_8000; mem[WB+2] = 32'h0000_4000;
        push(YB, 32'h0002_0000);
        run_layer(1'b0, cyc);
        chk("cycles_n2m1", 64'(cyc), 64'd9);

        rand_dly = 1'b1;
        setup_n3m2();
        run_layer(1'b0, cyc);
        rand_dly = 1'b0;
        repeat (8) @(posedge clk);

        setup_n1(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF);
        run_layer(1'b0, cyc);
        chk("cycles_n1m1", 64'(cyc), 64'd7);
        setup_n1(32'h7FFF_0000, 32'h8001_0000, 32'h8000_0000);
        run_layer(1'b0, cyc);
        // -2^-16 * 0.5 = -2^-17 floors to -2^-16
        setup_n1(32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF);
        run_layer(1'b0, cyc);

        // N=0: outputs are the biases and no X reads are made
        mem[3] = 0; mem[4] = 2;
        mem[WB] = 32'h0001_2345; mem[WB+1] = 32'hFFFF_8000;
        push(YB+0, 32'h0001_2345);
        push(YB+1, 32'hFFFF_8000);
        x_reads = 0;
        run_layer(1'b0, cyc);
        chk("n0_x_reads", 64'(x_reads), 64'd0);
        chk("cycles_n0m2", 64'(cyc), 64'd7);

        // M=0: no writes, done straight after the parameter reads
        mem[3] = 2; mem[4] = 0;
        run_layer(1'b0, cyc);
        chk("cycles_m0", 64'(cyc), 64'd3);

        // Reset while the row-1 weight read is pending
        setup_n3m2();
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        guard = 0;
        while (!(dram_en_rd && addr_in == 18'(WB+5)) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_row1_ld_w", 64'(guard < 200), 64'd1);
        #1 srstn = 1'b0;
        #1;
        chk("midrst_data_out", {32'd0, data_out}, 64'd0);
        chk("midrst_addr_out", {46'd0, addr_out}, 64'd0);
        chk("midrst_addr_in", {46'd0, addr_in}, 64'd0);
        chk("midrst_ctrl", {61'd0, dram_en_rd, dram_en_wr, done}, 64'd0);
        chk("midrst_row0_written", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_ctrl", {61'd0, dram_en_rd, dram_en_wr, done}, 64'd0);
        srstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_done", 64'(done_cnt), 64'd0);
        setup_n3m2();
        run_layer(1'b0, cyc);
        chk("cycles_rerun", 64'(cyc), 64'd19);

        // A second enable pulse during the MAC phase is ignored
        setup_n1(32'hFFFE_8000, 32'h0001_0000, 32'hFFFE_8000);
        run_layer(1'b1, cyc);
        chk("cycles_glitch", 64'(cyc), 64'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
